// File: rtl/hsv_core_issue_dispatch.sv
// Issue/dispatch stage: RAW/WAW hazard check against a 32-entry pending-register
// scoreboard, then routing of each accepted instruction into one of N_PORTS FIFOs.
module hsv_core_issue_dispatch #(
    parameter int N_PORTS    = 4,
    parameter int DATA_WIDTH = 128,
    parameter int DEPTH      = 2,
    localparam int PW        = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
    input  logic                          clk_core,
    input  logic                          rst_core_n,
    input  logic                          flush_req,
    output logic                          flush_ack,
    input  logic [DATA_WIDTH-1:0]         in_data,
    input  logic [PW-1:0]                 in_port,
    input  logic [4:0]                    in_rs1,
    input  logic [4:0]                    in_rs2,
    input  logic [4:0]                    in_rd,
    input  logic                          in_rs1_used,
    input  logic                          in_rs2_used,
    input  logic                          in_rd_we,
    input  logic                          valid_i,
    output logic                          ready_o,
    output logic [N_PORTS*DATA_WIDTH-1:0] out_data,
    output logic [N_PORTS-1:0]            out_valid_o,
    input  logic [N_PORTS-1:0]            out_ready_i,
    input  logic [31:0]                   commit_mask,
    output logic [31:0]                   pending_mask,
    output logic                          illegal_port_o
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CW   = AW + 1;
    localparam int NSEL = 1 << PW;

    logic [31:0]        pending_q, pending_d, set_vec;
    logic               flush_ack_q, illegal_q;
    logic [NSEL-1:0]    port_legal, full_ext;
    logic [N_PORTS-1:0] full, push, pop;
    logic               hazard, illegal_port, accept;

    // Port indices that decode past N_PORTS are accepted and dropped.
    for (genvar i = 0; i < NSEL; i++) begin : g_legal
        assign port_legal[i] = (i < N_PORTS);
    end

    always_comb begin
        full_ext              = '0;
        full_ext[N_PORTS-1:0] = full;
    end

    assign hazard       = (in_rs1_used & pending_q[in_rs1])
                        | (in_rs2_used & pending_q[in_rs2])
                        | (in_rd_we    & pending_q[in_rd]);
    assign illegal_port = ~port_legal[in_port];
    assign ready_o      = rst_core_n & ~flush_req & ~hazard & (illegal_port | ~full_ext[in_port]);
    assign accept       = valid_i & ready_o;

    always_comb begin
        set_vec = '0;
        if (accept && !illegal_port && in_rd_we && (in_rd != 5'd0)) begin
            set_vec[in_rd] = 1'b1;
        end
    end

    // A set in the same cycle as a commit of the same register wins.
    always_comb begin
        pending_d = (pending_q & ~commit_mask) | set_vec;
        if (flush_req) begin
            pending_d = '0;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk_core) begin
        if (!rst_core_n) begin
            pending_q   <= '0;
            flush_ack_q <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            pending_q   <= pending_d;
            flush_ack_q <= flush_req;
            illegal_q   <= accept & illegal_port;
        end
    end

    assign pending_mask   = pending_q;
    assign flush_ack      = flush_ack_q;
    assign illegal_port_o = illegal_q;

    for (genvar p = 0; p < N_PORTS; p++) begin : g_port
        logic [DATA_WIDTH-1:0] mem_q [DEPTH];
        logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
        logic [CW-1:0]         cnt_q, cnt_d;

        // Full comes from the registered count, so a pop never frees a slot in the same cycle.
        assign full[p]        = (cnt_q == CW'(DEPTH));
        assign out_valid_o[p] = rst_core_n & ~flush_req & (cnt_q != '0);
        assign push[p]        = accept & ~illegal_port & (in_port == PW'(p));
        assign pop[p]         = out_valid_o[p] & out_ready_i[p];
        assign out_data[p*DATA_WIDTH +: DATA_WIDTH] = mem_q[rd_ptr_q];

        always_comb begin
            wr_ptr_d = wr_ptr_q;
            rd_ptr_d = rd_ptr_q;
            cnt_d    = cnt_q;
            if (push[p]) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop[p]) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({push[p], pop[p]})
                2'b10:   cnt_d = cnt_q + CW'(1);
                2'b01:   cnt_d = cnt_q - CW'(1);
                default: cnt_d = cnt_q;
            endcase
            if (flush_req) begin
                wr_ptr_d = '0;
                rd_ptr_d = '0;
                cnt_d    = '0;
            end
        end

        always_ff @(posedge clk_core) begin
            if (!rst_core_n) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                cnt_q    <= '0;
            end else begin
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
                cnt_q    <= cnt_d;
            end
        end

        always_ff @(posedge clk_core) begin
            if (push[p]) begin
                mem_q[wr_ptr_q] <= in_data;
            end
        end
    end

endmodule

// File: tb/tb_hsv_core_issue_dispatch.sv
// Bench for hsv_core_issue_dispatch: queue-based reference model with a scoreboard,
// directed scenarios followed by randomized traffic including flushes and resets.
module tb_hsv_core_issue_dispatch;

    localparam int NP  = 3;
    localparam int DW  = 32;
    localparam int DEP = 2;
    localparam int PW  = 2;

    logic               clk_core = 1'b0;
    logic               rst_core_n, flush_req, flush_ack;
    logic [DW-1:0]      in_data;
    logic [PW-1:0]      in_port;
    logic [4:0]         in_rs1, in_rs2, in_rd;
    logic               in_rs1_used, in_rs2_used, in_rd_we;
    logic               valid_i, ready_o;
    logic [NP*DW-1:0]   out_data;
    logic [NP-1:0]      out_valid_o, out_ready_i;
    logic [31:0]        commit_mask, pending_mask;
    logic               illegal_port_o;

    always #5 clk_core = ~clk_core;

    hsv_core_issue_dispatch #(.N_PORTS(NP), .DATA_WIDTH(DW), .DEPTH(DEP)) dut (
        .clk_core(clk_core), .rst_core_n(rst_core_n),
        .flush_req(flush_req), .flush_ack(flush_ack),
        .in_data(in_data), .in_port(in_port),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_rs1_used(in_rs1_used), .in_rs2_used(in_rs2_used), .in_rd_we(in_rd_we),
        .valid_i(valid_i), .ready_o(ready_o),
        .out_data(out_data), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .commit_mask(commit_mask), .pending_mask(pending_mask),
        .illegal_port_o(illegal_port_o)
    );

    int            errors = 0;
    int            checks = 0;
    logic [DW-1:0] exp_q [NP][$];
    logic [31:0]   pend_m = '0;
    logic          ack_m = 1'b0;
    logic          ill_m = 1'b0;
    logic          exp_ready = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: compares every visible output against the model and retires popped entries.
    initial forever begin
        int   pi;
        logic hz, ill, fl, ev;
        @(negedge clk_core);
        pi  = int'(in_port);
        hz  = (in_rs1_used && pend_m[in_rs1]) || (in_rs2_used && pend_m[in_rs2])
           || (in_rd_we && pend_m[in_rd]);
        ill = (pi >= NP);
        fl  = 1'b0;
        if (!ill) fl = (exp_q[pi].size() >= DEP);
        exp_ready = rst_core_n && !flush_req && !hz && (ill || !fl);
        chk("ready_o", 32'(ready_o), 32'(exp_ready));
        for (int p = 0; p < NP; p++) begin
            ev = rst_core_n && !flush_req && (exp_q[p].size() != 0);
            chk($sformatf("out_valid[%0d]", p), 32'(out_valid_o[p]), 32'(ev));
            if (ev) begin
                chk($sformatf("out_data[%0d]", p), out_data[p*DW +: DW], exp_q[p][0]);
                if (out_ready_i[p]) void'(exp_q[p].pop_front());
            end
        end
        chk("pending_mask", pending_mask, pend_m);
        chk("flush_ack", 32'(flush_ack), 32'(ack_m));
        chk("illegal_port_o", 32'(illegal_port_o), 32'(ill_m));
    end

    // Reference model state update at each clock edge.
    initial forever begin
        int          pi;
        logic        acc;
        logic [31:0] setv;
        @(posedge clk_core);
        pi = int'(in_port);
        if (!rst_core_n || flush_req) begin
            for (int p = 0; p < NP; p++) exp_q[p].delete();
            pend_m = '0;
            ack_m  = rst_core_n && flush_req;
            ill_m  = 1'b0;
        end else begin
            acc  = valid_i && exp_ready;
            setv = '0;
            if (acc && pi < NP) begin
                exp_q[pi].push_back(in_data);
                if (in_rd_we && in_rd != 5'd0) setv[in_rd] = 1'b1;
            end
            ill_m  = acc && (pi >= NP);
            ack_m  = 1'b0;
            pend_m = (pend_m & ~commit_mask) | setv;
        end
    end

    task automatic step();
        @(posedge clk_core);
        #1;
    endtask

    task automatic set_in(input int port, input logic [DW-1:0] d, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [4:0] rd,
                          input logic u1, input logic u2, input logic we);
        in_port = PW'(port);
        in_data = d;
        in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
        in_rs1_used = u1; in_rs2_used = u2; in_rd_we = we;
    endtask

    task automatic issue(input int port, input logic [DW-1:0] d, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [4:0] rd,
                         input logic u1, input logic u2, input logic we, output int waited);
        set_in(port, d, rs1, rs2, rd, u1, u2, we);
        valid_i = 1'b1;
        waited  = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_core);
            if (ready_o) begin
                waited = i;
                break;
            end
        end
        if (waited < 0) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout got=stalled exp=accepted port=%0d t=%0t", port, $time);
        end
        step();
        valid_i = 1'b0;
    endtask

    initial begin
        int w;
        rst_core_n = 1'b0; flush_req = 1'b0; valid_i = 1'b1;
        commit_mask = '0; out_ready_i = '1;
        set_in(0, 32'hDEAD_0000, 0, 0, 0, 0, 0, 0);

        repeat (2) begin
            @(negedge clk_core);
            chk("rst_ready", 32'(ready_o), 0);
            chk("rst_valid", 32'(out_valid_o), 0);
            chk("rst_pending", pending_mask, 0);
            chk("rst_ack", 32'(flush_ack), 0);
        end
        step();
        rst_core_n = 1'b1;
        @(negedge clk_core);
        chk("rel_ready", 32'(ready_o), 1);
        step();
        valid_i = 1'b0;

        // RAW on x5 released by commit
        issue(0, 32'hA000_0005, 0, 0, 5, 0, 0, 1, w);
        set_in(1, 32'hB000_0005, 5, 0, 0, 1, 0, 0);
        valid_i = 1'b1;
        @(negedge clk_core);
        chk("raw_stall", 32'(ready_o), 0);
        chk("raw_pend", pending_mask, 32'h20);
        step();
        commit_mask = 32'h20;
        @(negedge clk_core);
        chk("raw_nobypass", 32'(ready_o), 0);
        step();
        commit_mask = '0;
        @(negedge clk_core);
        chk("raw_release", 32'(ready_o), 1);
        chk("raw_pend_clr", pending_mask, 0);
        step();
        valid_i = 1'b0;

        // Full FIFO on port 2
        out_ready_i[2] = 1'b0;
        issue(2, 32'hC000_000A, 0, 0, 0, 0, 0, 0, w);
        issue(2, 32'hC000_000B, 0, 0, 0, 0, 0, 0, w);
        set_in(2, 32'hC000_000C, 0, 0, 0, 0, 0, 0);
        valid_i = 1'b1;
        @(negedge clk_core);
        chk("full_stall", 32'(ready_o), 0);
        step();
        @(negedge clk_core);
        chk("full_stall2", 32'(ready_o), 0);
        step();
        out_ready_i[2] = 1'b1;
        @(negedge clk_core);
        chk("full_no_popthru", 32'(ready_o), 0);
        step();
        out_ready_i[2] = 1'b0;
        @(negedge clk_core);
        chk("full_release", 32'(ready_o), 1);
        step();
        valid_i = 1'b0;
        out_ready_i[2] = 1'b1;
        repeat (4) step();

        // Streaming through port 1 across pointer wrap
        for (int k = 0; k < 6; k++) begin
            issue(1, 32'h5000_0000 + 32'(k), 0, 0, 0, 0, 0, 0, w);
            chk("stream_nostall", w, 0);
        end
        repeat (2) step();

        // Flush with two entries in port 0 and x2/x3 pending
        out_ready_i[0] = 1'b0;
        issue(0, 32'hF000_0001, 0, 0, 2, 0, 0, 1, w);
        issue(0, 32'hF000_0002, 0, 0, 3, 0, 0, 1, w);
        @(negedge clk_core);
        chk("fl_pend", pending_mask, 32'h0C);
        chk("fl_valid_pre", 32'(out_valid_o[0]), 1);
        step();
        flush_req = 1'b1;
        @(negedge clk_core);
        chk("fl_valid", 32'(out_valid_o), 0);
        chk("fl_ack_lag", 32'(flush_ack), 0);
        step();
        flush_req = 1'b0;
        @(negedge clk_core);
        chk("fl_pend_clr", pending_mask, 0);
        chk("fl_ack", 32'(flush_ack), 1);
        chk("fl_valid_post", 32'(out_valid_o), 0);
        step();
        @(negedge clk_core);
        chk("fl_ack_fall", 32'(flush_ack), 0);
        out_ready_i[0] = 1'b1;
        issue(0, 32'hF000_0003, 2, 3, 0, 1, 1, 0, w);
        chk("fl_next", w, 0);

        // Illegal port index
        issue(3, 32'hEEEE_0007, 0, 0, 7, 0, 0, 1, w);
        chk("ill_accept", w, 0);
        @(negedge clk_core);
        chk("ill_pulse", 32'(illegal_port_o), 1);
        chk("ill_pend", pending_mask, 0);
        chk("ill_valid", 32'(out_valid_o), 0);
        step();
        @(negedge clk_core);
        chk("ill_fall", 32'(illegal_port_o), 0);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            rst_core_n  = ($urandom_range(0, 199) != 0);
            flush_req   = ($urandom_range(0, 39) == 0);
            valid_i     = ($urandom_range(0, 9) < 7);
            in_port     = ($urandom_range(0, 7) == 0) ? PW'(3) : PW'($urandom_range(0, 2));
            in_data     = $urandom;
            in_rs1      = 5'($urandom_range(0, 7));
            in_rs2      = 5'($urandom_range(0, 7));
            in_rd       = 5'($urandom_range(0, 7));
            in_rs1_used = 1'($urandom);
            in_rs2_used = 1'($urandom);
            in_rd_we    = 1'($urandom);
            commit_mask = ($urandom_range(0, 2) == 0) ? ($urandom & 32'hFF) : 32'h0;
            out_ready_i = NP'($urandom);
            step();
        end
        rst_core_n = 1'b1; flush_req = 1'b0; valid_i = 1'b0;
        commit_mask = '1; out_ready_i = '1;
        repeat (8) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hsv_core_issue_dispatch.md
# hsv_core_issue_dispatch

Parametrised issue/dispatch stage that replaces the fixed four-port hazard/fork/skid arrangement. It checks RAW and WAW hazards against a 32-entry register scoreboard and routes each accepted instruction to one of `N_PORTS` execution ports. Each port has its own `DEPTH`-entry FIFO. It sits between decode and the exec-mem processing units; commit feeds back a mask that retires pending destinations.

## Interface
Parameters:
- `N_PORTS`, default 4: number of execution ports; at least 1.
- `DATA_WIDTH`, default 128: width of the opaque per-instruction payload.
- `DEPTH`, default 2: entries per port FIFO; a power of two, at least 2.

Ports (`PW = $clog2(N_PORTS)`, minimum 1):
- `clk_core` in 1: core clock; the only clock.
- `rst_core_n` in 1: reset, synchronous, active-low.
- `flush_req` in 1: flush request.
- `flush_ack` out 1: flush acknowledge.
- `in_data` in DATA_WIDTH: instruction payload.
- `in_port` in PW: destination port index.
- `in_rs1`, `in_rs2`, `in_rd` in 5 each: source and destination register addresses.
- `in_rs1_used`, `in_rs2_used`, `in_rd_we` in 1 each: operand-used flags and destination write-enable.
- `valid_i` in 1 / `ready_o` out 1: input handshake.
- `out_data` out N_PORTS*DATA_WIDTH: per-port FIFO heads; port p occupies bits [p*DATA_WIDTH +: DATA_WIDTH].
- `out_valid_o` out N_PORTS / `out_ready_i` in N_PORTS: per-port output handshakes.
- `commit_mask` in 32: registers retired this cycle.
- `pending_mask` out 32: scoreboard state, for debug and verification.
- `illegal_port_o` out 1: one-cycle pulse when an accepted instruction had `in_port >= N_PORTS`.

## Operation
- **Scoreboard:** `pending[31:0]` is a register. Bit 0 is constant 0.
- **Hazard:** asserted if any of these hold, using the registered `pending` with no commit bypass:
  - `in_rs1_used & pending[in_rs1]`
  - `in_rs2_used & pending[in_rs2]`
  - `in_rd_we & pending[in_rd]` (WAW)
- **Ready:** `ready_o = rst_core_n & ~flush_req & ~hazard & (illegal_port | ~full[in_port])`. It may depend on the input fields, since they are valid whenever `valid_i` is high.
- **Accept** = `valid_i & ready_o`. On accept with a legal port:
  - push `in_data` into FIFO[`in_port`];
  - if `in_rd_we` and `in_rd != 0`, set `pending[in_rd]` next cycle.
- **Accept with illegal port:** payload is discarded, scoreboard is untouched, `illegal_port_o` = 1 the next cycle.
- **Commit:** `pending <= (pending & ~commit_mask) | set_bit`. If a bit is both set and cleared in the same cycle, set wins.
- **Per-port FIFO:**
  - circular buffer with `$clog2(DEPTH)`-bit read/write pointers that wrap modulo DEPTH, and a count from 0 to DEPTH;
  - `full` = (count == DEPTH), computed from registered count, so there is no same-cycle pop-through on full;
  - a pop occurs on `out_valid_o[p] & out_ready_i[p]`;
  - push and pop in the same cycle on a non-full, non-empty FIFO leave the count unchanged;
  - `out_data` for a port shows its head entry and is undefined while that port is empty.
- **Valid:** `out_valid_o[p] = (count_p != 0) & ~flush_req`.
- **Flush:** while `flush_req` is high, nothing is accepted or popped. Each cycle `flush_req` is sampled high:
  - all counts and pointers go to 0;
  - `pending` goes to 0, and commit and set are ignored.
- **Flush acknowledge:** `flush_ack` is `flush_req` delayed by one register.
- **Reset** (sampled low on an edge): `pending`, all counts, pointers, `flush_ack` and `illegal_port_o` are 0. During reset `ready_o` = 0 and `out_valid_o` = 0.

## Timing
- Input to output latency is 1 cycle: an instruction accepted at edge n has `out_valid_o` high after edge n and can be consumed at edge n+1.
- Port throughput is one instruction per cycle while the FIFO is not full.
- A full port blocks only instructions targeting it; with in-order single-input issue it still stalls the whole stream.
- Scoreboard update is 1 cycle: a dependent instruction presented the cycle after its producer is accepted sees the hazard.
- Commit to unstall costs 1 cycle: with `commit_mask` bit r at edge n, a consumer of r is ready in the cycle after edge n.
- `flush_ack` rises 1 cycle after `flush_req` rises and falls 1 cycle after it falls.
- Reset asserted mid-traffic behaves exactly like a flush plus clearing `flush_ack`. Entries in flight are lost.

## Test plan
- **Reset:** hold `rst_core_n` = 0 for 2 cycles with `valid_i` = 1 → `ready_o` = 0, `out_valid_o` = 0, `pending_mask` = 0, `flush_ack` = 0. After release, `ready_o` = 1.
- **RAW:** issue rd=5 to port 0, then rs1=5 to port 1 → second is stalled and `pending_mask` = 0x20. Pulse `commit_mask` = 0x20 → second is accepted the cycle after the commit and `pending_mask` = 0.
- **Full FIFO (DEPTH=2):**
  - issue 3 instructions to port 2 with `out_ready_i[2]` = 0 → first two accepted, third sees `ready_o` = 0;
  - raise `out_ready_i[2]` for 1 cycle → third is accepted the next cycle;
  - outputs come out in order A, B, C.
- **Simultaneous push/pop:** streaming to port 1 with `out_ready_i[1]` = 1 → count stays at 1, one instruction per cycle, data in order across pointer wrap (at least 5 items).
- **Flush:** with 2 entries in port 0 and `pending_mask` = 0x0C, pulse `flush_req` for 1 cycle → `out_valid_o` = 0, `pending_mask` = 0, `flush_ack` high for 1 cycle one cycle later, and the next instruction is accepted normally.
- **Illegal port:** with `N_PORTS` = 3, issue with `in_port` = 3 and rd=7 → accepted, `illegal_port_o` pulses for 1 cycle, `pending_mask` stays 0, no `out_valid_o` rises.
